fetch_stage: RTL and testbench

- Instruction fetch stage plus IF/ID pipeline register, directly upstream of pc_control_unit in the RSA pipeline CPU.
- Takes PCNext from the PC register and issues one instruction-memory request at a time.
- Holds the returned word in the IF/ID register and supplies Id/Imm to the PC logic and decode.
- Drives the PC register enable (PCEn), so the PC advances only once an instruction has actually been accepted.

---
 rtl/fetch_stage_if.sv | 25 ++
 rtl/fetch_stage.sv | 165 ++++++++++++++++
 tb/tb_fetch_stage.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response channel between fetch_stage (master) and imem (slave).
// One request is outstanding at a time; imem_valid returns 1..N cycles after imem_req.
interface fetch_stage_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_rdata;
    logic              imem_valid;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_valid
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_valid
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID register: one imem request at a time, a one-deep hold
// buffer for words returning under stall, and a PC-register enable pulsed per accepted word.
module fetch_stage #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] PCNext,
    input  logic              stall,
    input  logic              flush,
    fetch_stage_if.master     imem,
    output logic              PCEn,
    output logic [DATA_W-1:0] InstrD,
    output logic [ADDR_W-1:0] PCD,
    output logic              ValidD,
    output logic [3:0]        IdD,
    output logic [17:0]       ImmD,
    output logic              fetch_err
);

    localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, FETCH, WAIT, HOLD} state_e;

    state_e            state_q, state_d;
    logic              drop_q, drop_d;
    logic [ADDR_W-1:0] tag_q, tag_d;
    logic [DATA_W-1:0] hold_instr_q, hold_instr_d;
    logic [ADDR_W-1:0] hold_pc_q, hold_pc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;
    logic              req_q, req_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0] pcd_q, pcd_d;
    logic              valid_q, valid_d;
    logic              load_mem, load_hold;

    always_comb begin
        state_d      = state_q;
        drop_d       = drop_q;
        tag_d        = tag_q;
        hold_instr_d = hold_instr_q;
        hold_pc_d    = hold_pc_q;
        cnt_d        = cnt_q;
        err_d        = err_q;
        req_d        = 1'b0;
        addr_d       = addr_q;
        load_mem     = 1'b0;
        load_hold    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) state_d = FETCH;
            end
            FETCH: begin
                if (!start) begin
                    state_d = IDLE;
                end else begin
                    req_d   = 1'b1;
                    addr_d  = PCNext;
                    tag_d   = PCNext;
                    cnt_d   = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q < TMO) cnt_d = cnt_q + 1'b1;
                if (TIMEOUT != 0 && cnt_d == TMO) err_d = 1'b1;
                if (imem.imem_valid) begin
                    state_d = FETCH;
                    if (drop_q || flush) begin
                        // Response belongs to a redirected-away PC: discard it.
                        drop_d = 1'b0;
                    end else if (!valid_q || !stall) begin
                        load_mem = 1'b1;
                    end else begin
                        hold_instr_d = imem.imem_rdata;
                        hold_pc_d    = tag_q;
                        state_d      = HOLD;
                    end
                end else if (flush) begin
                    drop_d = 1'b1;
                end
            end
            HOLD: begin
                if (flush) begin
                    hold_instr_d = '0;
                    hold_pc_d    = '0;
                    state_d      = FETCH;
                end else if (!stall) begin
                    load_hold = 1'b1;
                    state_d   = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // IF/ID register: flush beats everything, a load beats consumption.
    always_comb begin
        instr_d = instr_q;
        pcd_d   = pcd_q;
        valid_d = valid_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (load_mem) begin
            instr_d = imem.imem_rdata;
            pcd_d   = tag_q;
            valid_d = 1'b1;
        end else if (load_hold) begin
            instr_d = hold_instr_q;
            pcd_d   = hold_pc_q;
            valid_d = 1'b1;
        end else if (!stall) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            drop_q       <= 1'b0;
            tag_q        <= '0;
            hold_instr_q <= '0;
            hold_pc_q    <= '0;
            cnt_q        <= '0;
            err_q        <= 1'b0;
            req_q        <= 1'b0;
            addr_q       <= '0;
            instr_q      <= '0;
            pcd_q        <= '0;
            valid_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            drop_q       <= drop_d;
            tag_q        <= tag_d;
            hold_instr_q <= hold_instr_d;
            hold_pc_q    <= hold_pc_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            req_q        <= req_d;
            addr_q       <= addr_d;
            instr_q      <= instr_d;
            pcd_q        <= pcd_d;
            valid_q      <= valid_d;
        end
    end

    // PCEn fires in the accepting cycle so the PC register has advanced before the next FETCH samples it.
    assign PCEn           = load_mem | load_hold;
    assign imem.imem_req  = req_q;
    assign imem.imem_addr = addr_q;
    assign InstrD         = instr_q;
    assign PCD            = pcd_q;
    assign ValidD         = valid_q;
    assign IdD            = instr_q[31:28];
    assign ImmD           = instr_q[17:0];
    assign fetch_err      = err_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: table-driven fetch stream, scoreboard on every PCEn, and directed
// hold / flush / timeout / async-reset sequences.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] PCNext;
    logic        PCEn, ValidD, fetch_err;
    logic [31:0] InstrD, PCD;
    logic [3:0]  IdD;
    logic [17:0] ImmD;

    fetch_stage_if #(.ADDR_W(32), .DATA_W(32)) imem_if ();

    fetch_stage #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(15)) dut (
        .clk(clk), .reset(reset), .start(start), .PCNext(PCNext), .stall(stall),
        .flush(flush), .imem(imem_if), .PCEn(PCEn), .InstrD(InstrD), .PCD(PCD),
        .ValidD(ValidD), .IdD(IdD), .ImmD(ImmD), .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        case (a)
            32'h00:  return 32'hC000_0010;
            32'h04:  return 32'h1234_5678;
            32'h08:  return 32'hFEDC_BA98;
            32'h40:  return 32'h5003_FFFF;
            32'h44:  return 32'h8000_0000;
            default: return 32'h7000_0000 | a;
        endcase
    endfunction

    function automatic int lat_of(input logic [31:0] a);
        case (a)
            32'h00:  return 1;
            32'h04:  return 3;
            32'h08:  return 3;
            32'h80:  return 6;
            default: return 2;
        endcase
    endfunction

    // PC register model: advances by 4 on PCEn, or is redirected by the test.
    logic [31:0] pc_r;
    logic        pc_set = 1'b0;
    logic [31:0] pc_set_val = 32'h0;
    always @(posedge clk or negedge reset) begin
        if (!reset)      pc_r <= 32'h0;
        else if (pc_set) pc_r <= pc_set_val;
        else if (PCEn)   pc_r <= pc_r + 32'd4;
    end
    assign PCNext = pc_r;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;
    exp_t sb[$];

    int          req_cnt = 0;
    int          pcen_cnt = 0;
    logic        pend = 1'b0;
    int          lcnt = 0;
    logic [31:0] paddr = 32'h0;
    logic [31:0] last_addr = 32'h0;
    logic        mem_mute = 1'b0;
    logic        skip_push = 1'b0;

    // Memory responder, acting on the falling edge.
    initial begin
        imem_if.imem_valid = 1'b0;
        imem_if.imem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            imem_if.imem_valid = 1'b0;
            if (pend) begin
                lcnt--;
                if (lcnt == 0) begin
                    pend = 1'b0;
                    imem_if.imem_valid = 1'b1;
                    imem_if.imem_rdata = mem_data(paddr);
                    if (skip_push) skip_push = 1'b0;
                    else sb.push_back({paddr, mem_data(paddr)});
                end
            end
            if (imem_if.imem_req) begin
                req_cnt++;
                last_addr = imem_if.imem_addr;
                chk("one_outstanding", {31'h0, pend}, 32'h0);
                if (!mem_mute) begin
                    pend  = 1'b1;
                    paddr = imem_if.imem_addr;
                    lcnt  = lat_of(imem_if.imem_addr);
                end
            end
        end
    end

    // Scoreboard: each PCEn must be followed by the matching word in IF/ID.
    logic cmp_pend = 1'b0;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #4;
            if (cmp_pend) begin
                cmp_pend = 1'b0;
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("sb_pcd", PCD, e.pc);
                    chk("sb_instr", InstrD, e.instr);
                    chk("sb_valid", {31'h0, ValidD}, 32'h1);
                end
            end
            if (PCEn) begin
                pcen_cnt++;
                cmp_pend = 1'b1;
                chk("pcen_has_word", {31'h0, sb.size() != 0}, 32'h1);
            end
        end
    end

    task automatic wait_pcen(input int n, input string nm);
        int k = 0;
        while (pcen_cnt < n && k < 60) begin
            @(negedge clk); #2;
            k++;
        end
        chk(nm, {31'h0, pcen_cnt >= n}, 32'h1);
    endtask

    task automatic wait_req(input int n, input string nm);
        int k = 0;
        while (req_cnt < n && k < 60) begin
            @(negedge clk); #2;
            k++;
        end
        chk(nm, {31'h0, req_cnt >= n}, 32'h1);
    endtask

    task automatic chk_zero_outs(input string tag);
        chk({tag, "_req"},    {31'h0, imem_if.imem_req}, 32'h0);
        chk({tag, "_addr"},   imem_if.imem_addr, 32'h0);
        chk({tag, "_pcen"},   {31'h0, PCEn}, 32'h0);
        chk({tag, "_instr"},  InstrD, 32'h0);
        chk({tag, "_pcd"},    PCD, 32'h0);
        chk({tag, "_valid"},  {31'h0, ValidD}, 32'h0);
        chk({tag, "_err"},    {31'h0, fetch_err}, 32'h0);
    endtask

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [3:0]  id;
        logic [17:0] imm;
    } vec_t;
    vec_t tbl[3];

    initial begin
        tbl[0] = '{32'h0, 32'hC000_0010, 4'hC, 18'h00010};
        tbl[1] = '{32'h4, 32'h1234_5678, 4'h1, 18'h05678};
        tbl[2] = '{32'h8, 32'hFEDC_BA98, 4'hF, 18'h0BA98};

        // Reset with start already high.
        start = 1'b1;
        repeat (3) begin @(negedge clk); #2; end
        chk_zero_outs("rst");
        reset = 1'b1;

        // Sequential fetch stream 0,4,8.
        wait_req(1, "first_req_seen");
        chk("first_req_addr", last_addr, 32'h0);
        for (int i = 0; i < 3; i++) begin
            wait_pcen(i + 1, "tbl_load_timeout");
            chk("tbl_instr", InstrD, tbl[i].instr);
            chk("tbl_pcd",   PCD, tbl[i].pc);
            chk("tbl_id",    {28'h0, IdD}, {28'h0, tbl[i].id});
            chk("tbl_imm",   {14'h0, ImmD}, {14'h0, tbl[i].imm});
            chk("tbl_valid", {31'h0, ValidD}, 32'h1);
        end
        start = 1'b0;
        repeat (3) begin @(negedge clk); #2; end
        chk("stream_pcen_cnt", pcen_cnt, 3);
        chk("stream_req_cnt", req_cnt, 3);
        chk("consumed_valid", {31'h0, ValidD}, 32'h0);

        // Second word returns under stall: held, then released.
        pc_set = 1'b1; pc_set_val = 32'h0;
        @(negedge clk); #2;
        pc_set = 1'b0;
        start = 1'b1;
        wait_pcen(4, "hold_first_load");
        stall = 1'b1;
        repeat (8) begin @(negedge clk); #2; end
        chk("hold_pcen_cnt", pcen_cnt, 4);
        chk("hold_instr", InstrD, 32'hC000_0010);
        chk("hold_valid", {31'h0, ValidD}, 32'h1);
        chk("hold_req_cnt", req_cnt, 5);
        chk("hold_sb_pending", sb.size(), 1);
        stall = 1'b0;
        start = 1'b0;
        wait_pcen(5, "hold_release");
        chk("hold_rel_instr", InstrD, 32'h1234_5678);
        chk("hold_rel_pcd", PCD, 32'h4);
        repeat (4) begin @(negedge clk); #2; end
        chk("hold_single_pcen", pcen_cnt, 5);

        // Flush in WAIT with redirect to 0x40.
        start = 1'b1;
        wait_req(6, "flush_req_seen");
        chk("flush_req_addr", last_addr, 32'h8);
        flush = 1'b1; pc_set = 1'b1; pc_set_val = 32'h40; skip_push = 1'b1;
        @(negedge clk); #2;
        flush = 1'b0; pc_set = 1'b0;
        chk("flush_validd", {31'h0, ValidD}, 32'h0);
        wait_req(7, "redirect_req_seen");
        chk("redirect_addr", last_addr, 32'h40);
        chk("dropped_no_pcen", pcen_cnt, 5);
        wait_pcen(6, "redirect_load");
        chk("redirect_instr", InstrD, 32'h5003_FFFF);
        chk("redirect_pcd", PCD, 32'h40);
        chk("redirect_id", {28'h0, IdD}, 32'h5);
        chk("redirect_imm", {14'h0, ImmD}, 32'h3FFFF);

        // Flush and stall together while ValidD=1: flush wins.
        flush = 1'b1; stall = 1'b1; start = 1'b0;
        @(negedge clk); #2;
        chk("flush_stall_valid", {31'h0, ValidD}, 32'h0);
        flush = 1'b0; stall = 1'b0;
        repeat (2) begin @(negedge clk); #2; end
        chk("flush_stall_req_cnt", req_cnt, 7);

        // Memory never answers: sticky timeout after 15 WAIT cycles.
        mem_mute = 1'b1;
        start = 1'b1;
        wait_req(8, "tmo_req_seen");
        repeat (14) begin @(negedge clk); #2; end
        chk("tmo_not_yet", {31'h0, fetch_err}, 32'h0);
        @(negedge clk); #2;
        chk("tmo_set", {31'h0, fetch_err}, 32'h1);
        repeat (20) begin @(negedge clk); #2; end
        chk("tmo_sticky", {31'h0, fetch_err}, 32'h1);

        // Reset clears the error; then async reset mid-WAIT with a late response.
        reset = 1'b0; start = 1'b0;
        @(negedge clk); #2;
        chk("rst_clears_err", {31'h0, fetch_err}, 32'h0);
        reset = 1'b1; mem_mute = 1'b0;
        pc_set = 1'b1; pc_set_val = 32'h80;
        @(negedge clk); #2;
        pc_set = 1'b0;
        start = 1'b1;
        wait_req(9, "late_req_seen");
        chk("late_req_addr", last_addr, 32'h80);
        skip_push = 1'b1;
        repeat (2) begin @(negedge clk); #2; end
        reset = 1'b0;
        #1;
        chk_zero_outs("async_rst");
        @(negedge clk); #2;
        start = 1'b0;
        reset = 1'b1;
        repeat (10) begin @(negedge clk); #2; end
        chk("late_valid_ignored", {31'h0, ValidD}, 32'h0);
        chk("late_instr_zero", InstrD, 32'h0);
        chk("late_no_pcen", pcen_cnt, 6);
        chk("sb_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
